// File: rtl/pin_handshake_tx_pkg.sv
// Shared types and constants for the outbound pin-level byte link.
package pin_handshake_tx_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REQ,
    REL,
    RECOVER
  } state_e;

  localparam int DEFAULT_DEPTH          = 4;
  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_SETUP_CYCLES   = 1;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Bit positions of the strobes inside uo_out / ui_in at the chip top.
  localparam int REQ_PIN_IDX = 0;
  localparam int ACK_PIN_IDX = 0;

endpackage

// File: rtl/pin_handshake_tx_byte_fifo.sv
// Small byte FIFO with a registered full flag so the producer-side ready
// never depends combinationally on any input.
module pin_handshake_tx_byte_fifo
  import pin_handshake_tx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  byte_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            do_push, do_pop;

  // A push while full is refused even when a pop happens in the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == LW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign level_o = count_q;

endmodule

// File: rtl/pin_handshake_tx.sv
// Outbound half of the pin-level byte link: buffers bytes from core logic and
// presents them on the uio pins with a 4-phase req/ack handshake.
module pin_handshake_tx
  import pin_handshake_tx_pkg::*;
#(
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int SETUP_CYCLES   = DEFAULT_SETUP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   ack_pin,
  output logic                   req_pin,
  output logic [7:0]             data_out,
  output logic [7:0]             data_oe,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   timeout_err,
  input  logic                   clr_err
);

  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam bit            TO_EN      = (TIMEOUT_CYCLES != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_sync;

  state_e                 state_q, state_d;
  logic [SW-1:0]          setup_cnt_q, setup_cnt_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   req_q, req_d;
  byte_t                  dout_q, dout_d;
  logic                   oe_q, oe_d;
  logic                   err_q, err_d;
  logic                   timed_out;

  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [7:0]             fifo_rdata;

  pin_handshake_tx_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // The FSM only ever looks at the last synchronizer stage.
  assign ack_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    to_cnt_d    = to_cnt_q;
    req_d       = req_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    err_d       = err_q;
    fifo_pop    = 1'b0;
    timed_out   = 1'b0;

    if (clr_err) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        dout_d = '0;
        oe_d   = 1'b0;
        if (!fifo_empty && !ack_sync) begin
          fifo_pop    = 1'b1;
          dout_d      = fifo_rdata;
          oe_d        = 1'b1;
          setup_cnt_d = '0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          req_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = REQ;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end
      REQ: begin
        if (ack_sync) begin
          req_d    = 1'b0;
          to_cnt_d = '0;
          state_d  = REL;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          timed_out = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      REL: begin
        if (!ack_sync) begin
          // Chain straight into the next byte so the bus stays driven.
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            dout_d      = fifo_rdata;
            setup_cnt_d = '0;
            state_d     = SETUP;
          end else begin
            oe_d    = 1'b0;
            dout_d  = '0;
            state_d = IDLE;
          end
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          timed_out = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        if (!ack_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A timeout drops the byte in flight; setting the flag beats a clear.
    if (timed_out) begin
      err_d   = 1'b1;
      req_d   = 1'b0;
      oe_d    = 1'b0;
      dout_d  = '0;
      state_d = RECOVER;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      setup_cnt_q <= '0;
      to_cnt_q    <= '0;
      req_q       <= 1'b0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ack_pin};
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      to_cnt_q    <= to_cnt_d;
      req_q       <= req_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign req_pin     = req_q;
  assign data_out    = dout_q;
  assign data_oe     = {8{oe_q}};
  assign timeout_err = err_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pin_handshake_tx.sv
// Directed + randomized bench for pin_handshake_tx with a behavioural host.
module tb_pin_handshake_tx;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int SETUP = 1;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ack_pin;
  logic       req_pin;
  logic [7:0] data_out;
  logic [7:0] data_oe;
  logic       busy;
  logic [2:0] level;
  logic       timeout_err;
  logic       clr_err;

  logic       man_ack;
  logic       host_en;
  logic       host_ack;
  int         hcnt, hdly, oe_bad;
  logic [7:0] rx_q[$];

  int         tests, fails;
  int         mon_bad, oe_falls, req_rises;
  logic       oe_prev, req_prev;

  always #5 clk = ~clk;

  assign ack_pin = host_en ? host_ack : man_ack;

  pin_handshake_tx #(
    .DEPTH          (DEPTH),
    .SYNC_STAGES    (SYNC),
    .SETUP_CYCLES   (SETUP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ack_pin     (ack_pin),
    .req_pin     (req_pin),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .busy        (busy),
    .level       (level),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  // Behavioural host: acks a few cycles after req rises, records the byte.
  initial begin
    host_ack = 1'b0; hcnt = 0; hdly = 0; oe_bad = 0;
    forever begin
      @(negedge clk);
      if (!host_en) begin
        host_ack = 1'b0; hcnt = 0;
      end else if (!host_ack) begin
        if (req_pin === 1'b1) begin
          if (hcnt >= hdly) begin
            rx_q.push_back(data_out);
            if (data_oe !== 8'hFF) oe_bad++;
            host_ack = 1'b1; hcnt = 0; hdly = $urandom_range(0, 2);
          end else hcnt++;
        end
      end else if (req_pin === 1'b0) begin
        if (hcnt >= hdly) begin
          host_ack = 1'b0; hcnt = 0; hdly = $urandom_range(0, 2);
        end else hcnt++;
      end
    end
  end

  // Passive monitor of pin-level events and the ready/level relation.
  initial begin
    mon_bad = 0; oe_falls = 0; req_rises = 0; oe_prev = 1'b0; req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((in_ready !== (int'(level) != DEPTH)) || (int'(level) > DEPTH)) mon_bad++;
      if (oe_prev === 1'b1 && data_oe === 8'h00) oe_falls++;
      if (req_prev === 1'b0 && req_pin === 1'b1) req_rises++;
      oe_prev  = (data_oe === 8'hFF);
      req_prev = req_pin;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, output logic waited);
    int n;
    n = 0; waited = 1'b0;
    in_data = b; in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 500) begin
      waited = 1'b1;
      @(negedge clk);
      n++;
    end
    check("push_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input logic v, input string tag);
    int n;
    n = 0;
    while (req_pin !== v && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, req_pin, v);
  endtask

  task automatic wait_drain(input int target, input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || rx_q.size() < target) && n < 2000) begin
      tick(1);
      n++;
    end
    check(tag, rx_q.size(), target);
  endtask

  initial begin
    int         n, base, bad, r0, of0, ph, gap;
    logic       w, saw_full;
    logic [7:0] exp_b[$];
    logic [7:0] cap[3];

    tests = 0; fails = 0;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; man_ack = 1'b0;
    clr_err = 1'b0; host_en = 1'b0;
    tick(3);
    check("rst_in_ready", in_ready, 1);
    check("rst_req", req_pin, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    tick(2);

    // Single byte, manual host: latency of data, req and release.
    in_data = 8'hA5; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check("t1_level_after_push", level, 1);
    check("t1_oe_before_pop", data_oe, 0);
    tick(1);
    check("t1_data", data_out, 8'hA5);
    check("t1_oe", data_oe, 8'hFF);
    check("t1_req_setup", req_pin, 0);
    tick(1);
    check("t1_req_rise", req_pin, 1);
    tick(3);
    check("t1_req_held", req_pin, 1);
    man_ack = 1'b1;
    tick(SYNC);
    check("t1_req_before_sync", req_pin, 1);
    tick(1);
    check("t1_req_fall", req_pin, 0);
    check("t1_data_stable", data_out, 8'hA5);
    tick(3);
    man_ack = 1'b0;
    tick(SYNC);
    check("t1_oe_in_rel", data_oe, 8'hFF);
    tick(1);
    check("t1_oe_idle", data_oe, 0);
    check("t1_data_idle", data_out, 0);
    check("t1_busy_idle", busy, 0);

    // Back-to-back 01..06 through a 4-deep FIFO.
    base = rx_q.size(); of0 = oe_falls; saw_full = 1'b0;
    host_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      n = i;
      push_byte(n[7:0], w);
      if (w) saw_full = 1'b1;
    end
    wait_drain(base + 6, "t2_rx_count");
    check("t2_saw_not_ready", saw_full, 1);
    check("t2_ready_after_drain", in_ready, 1);
    for (int i = 0; i < 6; i++) check("t2_rx_byte", rx_q[base + i], i + 1);
    check("t2_oe_single_drop", oe_falls - of0, 1);

    // Host never acks: timeout drops the byte, next byte goes normally.
    host_en = 1'b0; man_ack = 1'b0; base = rx_q.size();
    push_byte(8'h11, w);
    push_byte(8'h22, w);
    wait_req(1'b1, "t3_req_rise");
    n = 0;
    while (req_pin === 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check("t3_req_high_cycles", n, TMO);
    check("t3_err_set", timeout_err, 1);
    check("t3_oe_off", data_oe, 0);
    host_en = 1'b1;
    wait_drain(base + 1, "t3_rx_count");
    check("t3_rx_byte", rx_q[base], 8'h22);
    check("t3_err_sticky", timeout_err, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t3_err_cleared", timeout_err, 0);

    // Ack stuck high from reset holds off the transfer until it drops.
    host_en = 1'b0; man_ack = 1'b1; rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    base = rx_q.size();
    push_byte(8'h3C, w);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (req_pin !== 1'b0 || data_oe !== 8'h00) bad++;
    end
    check("t4_held_off", bad, 0);
    check("t4_level", level, 1);
    check("t4_busy", busy, 1);
    man_ack = 1'b0;
    tick(SYNC);
    check("t4_oe_before", data_oe, 0);
    tick(1);
    check("t4_oe_after", data_oe, 8'hFF);
    check("t4_data", data_out, 8'h3C);
    host_en = 1'b1;
    wait_drain(base + 1, "t4_rx_count");
    check("t4_rx_byte", rx_q[base], 8'h3C);

    // Reset while in REQ with two bytes queued.
    host_en = 1'b0; man_ack = 1'b0;
    push_byte(8'h51, w);
    push_byte(8'h52, w);
    push_byte(8'h53, w);
    wait_req(1'b1, "t5_req_rise");
    check("t5_level_queued", level, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_req_async", req_pin, 0);
    check("t5_oe_async", data_oe, 0);
    check("t5_level_async", level, 0);
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (req_pin !== 1'b0 || data_oe !== 8'h00 || busy !== 1'b0) bad++;
    end
    check("t5_quiet_after_reset", bad, 0);
    base = rx_q.size();
    host_en = 1'b1;
    push_byte(8'h5A, w);
    wait_drain(base + 1, "t5_rx_count");
    check("t5_rx_byte", rx_q[base], 8'h5A);

    // One-cycle ack pulses at random phase: one byte per pulse pair.
    host_en = 1'b0; man_ack = 1'b0;
    exp_b.delete();
    for (int i = 0; i < 3; i++) begin
      n = $urandom_range(0, 255);
      exp_b.push_back(n[7:0]);
      push_byte(n[7:0], w);
    end
    r0 = req_rises;
    for (int k = 0; k < 3; k++) begin
      wait_req(1'b1, "t6_req_rise");
      cap[k] = data_out;
      @(posedge clk);
      ph = $urandom_range(1, 8);
      #(ph) man_ack = 1'b1;
      #10 man_ack = 1'b0;
      tick(1);
      wait_req(1'b0, "t6_req_fall");
    end
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick(1);
      n++;
    end
    check("t6_idle", busy, 0);
    for (int k = 0; k < 3; k++) check("t6_byte", cap[k], exp_b[k]);
    check("t6_req_count", req_rises - r0, 3);

    // Random stream with random gaps and random host timing.
    exp_b.delete();
    base = rx_q.size();
    host_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n = $urandom_range(0, 255);
      gap = $urandom_range(0, 3);
      exp_b.push_back(n[7:0]);
      push_byte(n[7:0], w);
      if (gap > 0) tick(gap);
    end
    wait_drain(base + 16, "t7_rx_count");
    bad = 0;
    for (int i = 0; i < 16; i++) if (rx_q[base + i] !== exp_b[i]) bad++;
    check("t7_stream", bad, 0);
    check("t7_no_timeout", timeout_err, 0);

    check("host_oe_at_ack", oe_bad, 0);
    check("ready_level_relation", mon_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
